// File: rtl/pmem_resp_pkg.sv
// Shared definitions for the physical-memory line responder.
// Holds the default geometry of a cacheline and its burst beats, the beat and
// line types built from that geometry, and the responder's state encoding.
package pmem_resp_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BEAT_WIDTH  = 64;
  localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
  localparam int OFFSET_BITS = 5;

  typedef logic [BEAT_WIDTH-1:0] beat_t;

  // Element 0 is the lowest-addressed beat, i.e. line bits [BEAT_WIDTH-1:0].
  typedef beat_t [BEATS-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/line_beat_buffer.sv
// Beat-organised line buffer used by the responder.
// Holds BEATS beats of BEAT_WIDTH bits. A whole line can be loaded in parallel
// (write data latch) or a single beat can be loaded by index (read capture).
// A whole-line load takes priority over a single-beat load.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset, clears every beat
//   load_line  load all beats from line_in
//   line_in    full line, beat 0 in the low bits
//   load_beat  load the beat selected by beat_idx from beat_in
//   beat_idx   beat index for load_beat
//   beat_in    beat data for load_beat
//   rd_idx     beat index for beat_out
//   beat_out   selected beat (combinational from rd_idx)
//   line_out   all beats, beat 0 in the low bits
module line_beat_buffer #(
  parameter int BEAT_WIDTH = pmem_resp_pkg::BEAT_WIDTH,
  parameter int BEATS      = pmem_resp_pkg::BEATS,
  parameter int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_line,
  input  logic [BEATS*BEAT_WIDTH-1:0] line_in,
  input  logic                        load_beat,
  input  logic [IDX_W-1:0]            beat_idx,
  input  logic [BEAT_WIDTH-1:0]       beat_in,
  input  logic [IDX_W-1:0]            rd_idx,
  output logic [BEAT_WIDTH-1:0]       beat_out,
  output logic [BEATS*BEAT_WIDTH-1:0] line_out
);

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      logic [BEAT_WIDTH-1:0] beat_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          beat_reg <= '0;
        end else if (load_line) begin
          beat_reg <= line_in[gi*BEAT_WIDTH +: BEAT_WIDTH];
        end else if (load_beat && (beat_idx == IDX_W'(gi))) begin
          beat_reg <= beat_in;
        end
      end

      assign line_out[gi*BEAT_WIDTH +: BEAT_WIDTH] = beat_reg;
    end
  endgenerate

  assign beat_out = line_out[rd_idx*BEAT_WIDTH +: BEAT_WIDTH];

endmodule

// File: rtl/pmem_line_responder.sv
// Physical-memory-side responder for the cache's whole-line interface.
// A line read or write from the cache is serviced as a BEATS-beat burst to the
// off-chip memory model; completion is signalled with a one-cycle line_resp.
// Requests are only sampled in IDLE; a simultaneous read and write is served
// read first and the write stays pending until the read has completed.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   line_address   line request address (offset bits are dropped)
//   line_read      line read request, held until line_resp
//   line_write     line write request, held until line_resp
//   line_wdata     line to write, latched when the request is accepted
//   line_rdata     assembled read line, updated only when a read completes
//   line_resp      one-cycle completion pulse
//   burst_address  line-aligned burst address
//   burst_read     burst read strobe, held for the whole burst
//   burst_write    burst write strobe, held for the whole burst
//   burst_wdata    current write beat
//   burst_rdata    returned read beat
//   burst_resp     one beat transferred this cycle
module pmem_line_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = pmem_resp_pkg::LINE_WIDTH,
  parameter int BEAT_WIDTH  = pmem_resp_pkg::BEAT_WIDTH,
  parameter int OFFSET_BITS = pmem_resp_pkg::OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] line_address,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [LINE_WIDTH-1:0] line_wdata,
  output logic [LINE_WIDTH-1:0] line_rdata,
  output logic                  line_resp,
  output logic [ADDR_WIDTH-1:0] burst_address,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [BEAT_WIDTH-1:0] burst_wdata,
  input  logic [BEAT_WIDTH-1:0] burst_rdata,
  input  logic                  burst_resp
);

  import pmem_resp_pkg::*;

  localparam int NUM_BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [LINE_WIDTH-1:0] buf_line;
  logic [LINE_WIDTH-1:0] capture_line;
  logic                  load_line;
  logic                  load_beat;
  logic                  unused_offset;

  // The offset bits never reach the burst side.
  assign unused_offset = ^line_address[OFFSET_BITS-1:0];

  // The write line is latched on any accepted request; a read then overwrites
  // the buffer beat by beat, which is harmless because line_rdata is separate.
  assign load_line = (state_reg == IDLE) && (line_read || line_write);
  assign load_beat = (state_reg == RD) && burst_resp;

  line_beat_buffer #(
    .BEAT_WIDTH (BEAT_WIDTH),
    .BEATS      (NUM_BEATS),
    .IDX_W      (CNT_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load_line (load_line),
    .line_in   (line_wdata),
    .load_beat (load_beat),
    .beat_idx  (cnt_reg),
    .beat_in   (burst_rdata),
    .rd_idx    (cnt_reg),
    .beat_out  (burst_wdata),
    .line_out  (buf_line)
  );

  // Buffer contents with the beat arriving this cycle merged in, so the
  // complete line can be published on the same edge as the last beat and is
  // never partially visible on line_rdata.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BEATS; gi++) begin : g_capture
      assign capture_line[gi*BEAT_WIDTH +: BEAT_WIDTH] =
          (cnt_reg == CNT_W'(gi)) ? burst_rdata
                                  : buf_line[gi*BEAT_WIDTH +: BEAT_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      burst_address <= '0;
      burst_read    <= 1'b0;
      burst_write   <= 1'b0;
      line_resp     <= 1'b0;
      line_rdata    <= '0;
    end else begin
      line_resp <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (line_read || line_write) begin
            burst_address <= {line_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            cnt_reg       <= '0;
          end
          if (line_read) begin
            burst_read <= 1'b1;
            state_reg  <= RD;
          end else if (line_write) begin
            burst_write <= 1'b1;
            state_reg   <= WR;
          end
        end

        RD: begin
          if (burst_resp) begin
            if (cnt_reg == LAST_BEAT) begin
              cnt_reg    <= '0;
              line_rdata <= capture_line;
              burst_read <= 1'b0;
              line_resp  <= 1'b1;
              state_reg  <= DONE;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end

        WR: begin
          if (burst_resp) begin
            if (cnt_reg == LAST_BEAT) begin
              cnt_reg     <= '0;
              burst_write <= 1'b0;
              line_resp   <= 1'b1;
              state_reg   <= DONE;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_line_responder.sv
module tb_pmem_line_responder;
  import pmem_resp_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [31:0]  line_address;
  logic         line_read;
  logic         line_write;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: read beats the memory model will return, expected read lines,
  // expected write beats in burst order.
  beat_t mem_q[$];
  line_t rd_q[$];
  beat_t wr_q[$];
  line_t last_read;

  pmem_line_responder dut (
    .clk           (clk),
    .rst           (rst_n),
    .line_address  (line_address),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_wdata    (line_wdata),
    .line_rdata    (line_rdata),
    .line_resp     (line_resp),
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Memory model: supplies the next queued read beat on a cycle where a beat
  // is transferred, garbage otherwise.
  task automatic drive_beat(input bit resp);
    burst_resp = resp;
    if (resp && burst_read && mem_q.size() > 0) burst_rdata = mem_q.pop_front();
    else burst_rdata = {$urandom(), $urandom()};
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < BEATS; i++) l[i] = {$urandom(), $urandom()};
    return l;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; line_address = '0; line_read = 1'b0; line_write = 1'b0;
    line_wdata = '0; burst_rdata = '0; burst_resp = 1'b0;
    last_read = '0;
    #1;
    checks++;
    if ({line_resp, burst_read, burst_write} !== 3'b000) begin
      failures++;
      $display("FAIL reset_strobes: resp/rd/wr=%b required 000", {line_resp, burst_read, burst_write});
    end
    checks++;
    if (line_rdata !== '0 || burst_wdata !== '0 || burst_address !== '0) begin
      failures++;
      $display("FAIL reset_data: rdata=%h wdata=%h addr=%h required all zero", line_rdata, burst_wdata, burst_address);
    end
    line_read = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (burst_read !== 1'b0 || line_resp !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: burst_read=%b line_resp=%b required 0 0", burst_read, line_resp);
    end
    line_read = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    $display("txn reset done");
  endtask

  task automatic run_read(input string tag, input logic [31:0] addr, input line_t data,
                          input logic [15:0] resp_mask, input int exp_cycle);
    line_t       exp_line;
    logic [31:0] exp_addr;
    int resp_cycle, nresp, rd_cycles, both;
    #1;
    exp_addr = addr & 32'hFFFF_FFE0;
    for (int i = 0; i < BEATS; i++) mem_q.push_back(data[i]);
    rd_q.push_back(data);
    line_address = addr; line_read = 1'b1;
    resp_cycle = 0; nresp = 0; rd_cycles = 0; both = 0;
    @(posedge clk);
    for (int cyc = 1; cyc <= exp_cycle + 3; cyc++) begin
      #1;
      if (burst_read) rd_cycles++;
      if (burst_read && burst_write) both++;
      if (cyc == 1) begin
        checks++;
        if (burst_address !== exp_addr) begin
          failures++;
          $display("FAIL %s_addr: burst_address=%h required %h", tag, burst_address, exp_addr);
        end
      end
      if (line_resp) begin
        nresp++;
        if (resp_cycle == 0) resp_cycle = cyc;
        line_read = 1'b0;
        checks++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL %s_rdata: line_resp with no read outstanding", tag);
        end else begin
          exp_line = rd_q.pop_front();
          if (line_rdata !== exp_line) begin
            failures++;
            $display("FAIL %s_rdata: line_rdata=%h required %h", tag, line_rdata, exp_line);
          end
        end
      end
      drive_beat(resp_mask[cyc]);
      @(posedge clk);
    end
    line_read = 1'b0;
    #1;
    checks++;
    if (line_rdata !== data) begin
      failures++;
      $display("FAIL %s_hold: line_rdata=%h required %h", tag, line_rdata, data);
    end
    checks++;
    if (resp_cycle != exp_cycle || nresp != 1) begin
      failures++;
      $display("FAIL %s_latency: resp_cycle=%0d pulses=%0d required %0d and 1", tag, resp_cycle, nresp, exp_cycle);
    end
    checks++;
    if (rd_cycles != exp_cycle - 1 || both != 0 || mem_q.size() != 0) begin
      failures++;
      $display("FAIL %s_burst: read_cycles=%0d overlap=%0d beats_left=%0d required %0d 0 0",
               tag, rd_cycles, both, mem_q.size(), exp_cycle - 1);
    end
    mem_q.delete(); rd_q.delete();
    last_read = data;
    @(posedge clk);
    $display("txn %s read addr=%h resp_cycle=%0d line=%h", tag, addr, resp_cycle, line_rdata);
  endtask

  task automatic run_write(input string tag, input logic [31:0] addr, input line_t data,
                           input logic [15:0] resp_mask, input int exp_cycle);
    beat_t       exp_beat;
    logic [31:0] exp_addr;
    int resp_cycle, nresp, both;
    #1;
    exp_addr = addr & 32'hFFFF_FFE0;
    for (int i = 0; i < BEATS; i++) wr_q.push_back(data[i]);
    line_address = addr; line_wdata = data; line_write = 1'b1;
    resp_cycle = 0; nresp = 0; both = 0;
    @(posedge clk);
    for (int cyc = 1; cyc <= exp_cycle + 3; cyc++) begin
      #1;
      if (burst_read && burst_write) both++;
      if (cyc == 1) begin
        checks++;
        if (burst_address !== exp_addr) begin
          failures++;
          $display("FAIL %s_addr: burst_address=%h required %h", tag, burst_address, exp_addr);
        end
      end
      if (cyc == 2) begin
        // Mid-burst changes must not affect the burst.
        line_address = ~addr; line_wdata = ~data;
      end
      if (line_resp) begin
        nresp++;
        if (resp_cycle == 0) resp_cycle = cyc;
        line_write = 1'b0;
      end
      drive_beat(resp_mask[cyc]);
      if (burst_write && burst_resp) begin
        checks++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("FAIL %s_wdata: extra beat %h", tag, burst_wdata);
        end else begin
          exp_beat = wr_q.pop_front();
          if (burst_wdata !== exp_beat) begin
            failures++;
            $display("FAIL %s_wdata: burst_wdata=%h required %h", tag, burst_wdata, exp_beat);
          end
        end
      end
      @(posedge clk);
    end
    line_write = 1'b0;
    #1;
    checks++;
    if (resp_cycle != exp_cycle || nresp != 1 || both != 0 || wr_q.size() != 0) begin
      failures++;
      $display("FAIL %s_latency: resp_cycle=%0d pulses=%0d overlap=%0d beats_left=%0d required %0d 1 0 0",
               tag, resp_cycle, nresp, both, wr_q.size(), exp_cycle);
    end
    checks++;
    if (line_rdata !== last_read) begin
      failures++;
      $display("FAIL %s_rdata_kept: line_rdata=%h required %h", tag, line_rdata, last_read);
    end
    wr_q.delete();
    @(posedge clk);
    $display("txn %s write addr=%h resp_cycle=%0d", tag, addr, resp_cycle);
  endtask

  task automatic test_read_no_stall();
    line_t d;
    d[0] = 64'h1111_1111_1111_1111; d[1] = 64'h2222_2222_2222_2222;
    d[2] = 64'h3333_3333_3333_3333; d[3] = 64'h4444_4444_4444_4444;
    run_read("read_nostall", 32'h0000_1234, d, 16'hFFFE, 5);
  endtask

  task automatic test_write();
    line_t d;
    d = 256'h0123456789ABCDEF_C0C1C2C3C4C5C6C7_B0B1B2B3B4B5B6B7_A0A1A2A3A4A5CDEF;
    run_write("write", 32'h8000_003F, d, 16'hFFFE, 5);
    run_write("write_stall", 32'h0000_0540, rand_line(), 16'h0264, 10);
  endtask

  task automatic test_stalled_read();
    run_read("read_stall", 32'h0000_2000, rand_line(), 16'h0264, 10);
  endtask

  task automatic test_back_to_back();
    line_t rdat, wdat, exp_line;
    beat_t exp_beat;
    int nresp, both, first_rd, first_wr, resp1, resp2;
    #1;
    rdat = rand_line(); wdat = rand_line();
    for (int i = 0; i < BEATS; i++) begin
      mem_q.push_back(rdat[i]);
      wr_q.push_back(wdat[i]);
    end
    rd_q.push_back(rdat);
    line_address = 32'h0000_3300; line_wdata = wdat;
    line_read = 1'b1; line_write = 1'b1;
    nresp = 0; both = 0; first_rd = 0; first_wr = 0; resp1 = 0; resp2 = 0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      #1;
      if (burst_read && burst_write) both++;
      if (burst_read && first_rd == 0) first_rd = cyc;
      if (burst_write && first_wr == 0) first_wr = cyc;
      if (line_resp) begin
        nresp++;
        if (nresp == 1) begin
          resp1 = cyc;
          line_read = 1'b0;
          checks++;
          exp_line = (rd_q.size() > 0) ? rd_q.pop_front() : ~rdat;
          if (line_rdata !== exp_line) begin
            failures++;
            $display("FAIL b2b_rdata: line_rdata=%h required %h", line_rdata, exp_line);
          end
        end else begin
          resp2 = cyc;
          line_write = 1'b0;
        end
      end
      drive_beat(1'b1);
      if (burst_write && burst_resp) begin
        checks++;
        exp_beat = (wr_q.size() > 0) ? wr_q.pop_front() : ~burst_wdata;
        if (burst_wdata !== exp_beat) begin
          failures++;
          $display("FAIL b2b_wdata: burst_wdata=%h required %h", burst_wdata, exp_beat);
        end
      end
      @(posedge clk);
    end
    line_read = 1'b0; line_write = 1'b0;
    checks++;
    if (nresp != 2 || resp1 != 5 || resp2 != 11) begin
      failures++;
      $display("FAIL b2b_resp: pulses=%0d at %0d,%0d required 2 at 5,11", nresp, resp1, resp2);
    end
    checks++;
    if (both != 0 || first_rd != 1 || first_wr != 7) begin
      failures++;
      $display("FAIL b2b_order: overlap=%0d read_start=%0d write_start=%0d required 0 1 7", both, first_rd, first_wr);
    end
    last_read = rdat;
    mem_q.delete(); rd_q.delete(); wr_q.delete();
    $display("txn back_to_back read+write resp_cycles=%0d,%0d", resp1, resp2);
  endtask

  task automatic test_async_reset();
    int nresp;
    #1;
    line_address = 32'h0000_7700; line_wdata = rand_line(); line_write = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      #1;
      drive_beat(1'b1);
      if (cyc < 3) @(posedge clk);
    end
    // Cycle 3 carries beat 2; pull reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (burst_write !== 1'b0 || line_resp !== 1'b0) begin
      failures++;
      $display("FAIL areset_strobes: burst_write=%b line_resp=%b required 0 0", burst_write, line_resp);
    end
    checks++;
    if (burst_address !== '0 || burst_wdata !== '0 || line_rdata !== '0) begin
      failures++;
      $display("FAIL areset_data: addr=%h wdata=%h rdata=%h required all zero", burst_address, burst_wdata, line_rdata);
    end
    line_write = 1'b0;
    last_read = '0;
    nresp = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (line_resp || burst_write || burst_read) nresp++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (line_resp || burst_write || burst_read) nresp++;
    end
    checks++;
    if (nresp != 0) begin
      failures++;
      $display("FAIL areset_quiet: active_cycles=%0d required 0", nresp);
    end
    @(posedge clk);
    $display("txn async_reset mid-write abandoned");
    run_read("post_reset", 32'h0000_4560, rand_line(), 16'hFFFE, 5);
  endtask

  task automatic test_stray_resp();
    int nresp;
    nresp = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      #1;
      if (line_resp || burst_read || burst_write) nresp++;
      burst_resp = 1'b1;
      burst_rdata = {$urandom(), $urandom()};
      @(posedge clk);
    end
    #1;
    checks++;
    if (nresp != 0 || line_resp !== 1'b0) begin
      failures++;
      $display("FAIL stray_idle: active_cycles=%0d line_resp=%b required 0 0", nresp, line_resp);
    end
    @(posedge clk);
    $display("txn stray burst_resp in idle");
    run_read("stray_read", 32'h0000_ABCD, rand_line(), 16'hFFFE, 5);
  endtask

  initial begin
    test_reset();
    test_read_no_stall();
    test_write();
    test_stalled_read();
    test_back_to_back();
    test_async_reset();
    test_stray_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
